keypad_emulator: RTL

- Responder side of the PMOD 4x4 keypad scan interface: plays a programmed digit sequence as physical key presses.
- Watches the column lines driven by the keypad scanner and pulls the matching row line low while a key is "pressed".
- Used for self-play/demo mode and as a synthesizable stimulus source for the game's keypad input path in benches.
- A completed 4-digit run leaves the scanner-side shift buffer holding exactly the programmed value.

---
 rtl/keypad_pkg.sv | 57 +++++
 rtl/keypad_row_driver.sv | 35 +++
 rtl/keypad_emulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Key codes and key-position map shared by the keypad scanner and the
// keypad emulator, so both sides decode presses identically.
package keypad_pkg;

   localparam logic [3:0] KEY_0 = 4'h0;
   localparam logic [3:0] KEY_1 = 4'h1;
   localparam logic [3:0] KEY_2 = 4'h2;
   localparam logic [3:0] KEY_3 = 4'h3;
   localparam logic [3:0] KEY_4 = 4'h4;
   localparam logic [3:0] KEY_5 = 4'h5;
   localparam logic [3:0] KEY_6 = 4'h6;
   localparam logic [3:0] KEY_7 = 4'h7;
   localparam logic [3:0] KEY_8 = 4'h8;
   localparam logic [3:0] KEY_9 = 4'h9;
   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;   // start/confirm key

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_RELEASE = 2'd2
   } kp_state_e;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } key_pos_t;

   // Physical position of a key on the 4x4 pad (index 0 = bit 0 of row/col).
   function automatic key_pos_t key_to_rowcol(input logic [3:0] code);
      key_pos_t pos;
      case (code)
         KEY_1:   pos = '{row: 2'd0, col: 2'd0};
         KEY_2:   pos = '{row: 2'd0, col: 2'd1};
         KEY_3:   pos = '{row: 2'd0, col: 2'd2};
         KEY_A:   pos = '{row: 2'd0, col: 2'd3};
         KEY_4:   pos = '{row: 2'd1, col: 2'd0};
         KEY_5:   pos = '{row: 2'd1, col: 2'd1};
         KEY_6:   pos = '{row: 2'd1, col: 2'd2};
         KEY_B:   pos = '{row: 2'd1, col: 2'd3};
         KEY_7:   pos = '{row: 2'd2, col: 2'd0};
         KEY_8:   pos = '{row: 2'd2, col: 2'd1};
         KEY_9:   pos = '{row: 2'd2, col: 2'd2};
         KEY_C:   pos = '{row: 2'd2, col: 2'd3};
         KEY_0:   pos = '{row: 2'd3, col: 2'd0};
         KEY_F:   pos = '{row: 2'd3, col: 2'd1};
         KEY_E:   pos = '{row: 2'd3, col: 2'd2};
         default: pos = '{row: 2'd3, col: 2'd3};   // KEY_D
      endcase
      return pos;
   endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Row return driver: pulls the pressed key's row low while its column is
// strobed. Registered, so row follows col with one cycle of latency.
module keypad_row_driver
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_active,
   input  logic [3:0] cur_key,
   input  logic [3:0] col,
   output logic [3:0] row
);

   key_pos_t   pos;
   logic [3:0] row_d;
   logic [3:0] row_q;

   // Row pattern for the current key against the strobed column(s).
   always_comb begin
      pos   = key_to_rowcol(cur_key);
      row_d = 4'hF;
      if (key_active && !col[pos.col]) begin
         row_d[pos.row] = 1'b0;
      end
   end

   // Output register; reset releases all rows immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) row_q <= 4'hF;
      else     row_q <= row_d;
   end

   assign row = row_q;

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: plays a captured digit sequence as timed key presses
// on the responder side of a 4x4 column-scanned keypad.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | waiting for start; rows released
//   ST_PRESS   | top nibble of the sequence held pressed for HOLD_CYCLES
//   ST_RELEASE | all keys released for GAP_CYCLES; then next digit or done
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_CYCLES = 2000000,
   parameter int GAP_CYCLES  = 2000000,
   parameter int NUM_DIGITS  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [3:0]              col,
   output logic [3:0]              row,
   output logic                    busy,
   output logic                    done,
   output logic                    key_active,
   output logic [3:0]              cur_key
);

   localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int CNT_W   = $clog2(NUM_DIGITS) + 1;
   localparam int SEQ_W   = 4 * NUM_DIGITS;

   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_DIGITS - 1);

   kp_state_e         state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              busy_q, busy_d;
   logic              tmr_zero;
   logic              last_digit;

   assign tmr_zero   = (tmr_q == '0);
   assign last_digit = (cnt_q == LAST_IDX);

   // State, timer, digit counter and sequence registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         seq_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; done is raised during the final release cycle so a
   // start coinciding with it is still seen in RELEASE and ignored.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      seq_d   = seq_q;
      busy_d  = busy_q;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               seq_d   = digits;
               cnt_d   = '0;
               tmr_d   = HOLD_LOAD;
               busy_d  = 1'b1;
               state_d = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (tmr_zero) begin
               tmr_d   = GAP_LOAD;
               state_d = ST_RELEASE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_RELEASE: begin
            if (tmr_zero) begin
               if (last_digit) begin
                  done    = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  seq_d   = seq_q << 4;
                  cnt_d   = cnt_q + CNT_W'(1);
                  tmr_d   = HOLD_LOAD;
                  state_d = ST_PRESS;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy       = busy_q;
   assign key_active = (state_q == ST_PRESS);
   assign cur_key    = seq_q[SEQ_W-1 -: 4];

   keypad_row_driver u_row_driver (
      .clk        (clk),
      .rst        (rst),
      .key_active (key_active),
      .cur_key    (cur_key),
      .col        (col),
      .row        (row)
   );

endmodule
